// File: rtl/gene_pkg.sv
// Shared base-code and ASCII constants for the gene line compressor/decompressor pair,
// plus the decompressor state encoding.
package gene_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_G  = 8'h47;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {EMPTY, EMIT, NL} state_t;

endpackage

// File: rtl/base_code_to_ascii.sv
// Combinational map from a 2-bit base code to its ASCII character.
module base_code_to_ascii
    import gene_pkg::*;
(
    input  logic [1:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_A;
        unique case (code)
            BASE_A: ascii = ASCII_A;
            BASE_C: ascii = ASCII_C;
            BASE_G: ascii = ASCII_G;
            BASE_T: ascii = ASCII_T;
        endcase
    end

endmodule

// File: rtl/gene_line_decompress.sv
// Unpacks bytes of four 2-bit base codes into an ASCII stream with per-line end marking.
// Optional NEWLINE_INSERT_EN appends an LF beat after every LINE_LEN bases.
module gene_line_decompress
    import gene_pkg::*;
#(
    parameter int unsigned LINE_LEN = 100,
    parameter int unsigned CNT_W    = $clog2(LINE_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    state_t           state;
    logic [7:0]       byte_reg;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane;
    logic [7:0]       lane_ascii;
    logic             last_base;
    logic             line_end;
    logic             in_xfer;
`ifdef NEWLINE_INSERT_EN
    logic             pending;
`endif

    assign lane      = byte_reg[{idx, 1'b0} +: 2];
    assign last_base = (idx == 2'd3);
    assign line_end  = (cnt == CNT_W'(LINE_LEN - 1));
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid && in_ready;

    base_code_to_ascii u_map (
        .code  (lane),
        .ascii (lane_ascii)
    );

    // in_ready opens on the last base of a byte so the next byte lands with no bubble.
    always_comb begin
        in_ready = 1'b0;
        out_data = 8'h00;
        case (state)
            EMPTY: in_ready = 1'b1;
            EMIT: begin
                in_ready = last_base && out_ready;
                out_data = lane_ascii;
            end
            NL:      out_data = ASCII_LF;
            default: ;
        endcase
    end

`ifdef NEWLINE_INSERT_EN
    assign out_last = (state == NL);
`else
    assign out_last = (state == EMIT) && line_end;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            byte_reg <= 8'h00;
            idx      <= 2'd0;
            cnt      <= '0;
`ifdef NEWLINE_INSERT_EN
            pending  <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        byte_reg <= in_data;
                        idx      <= 2'd0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
`ifdef NEWLINE_INSERT_EN
                        cnt <= cnt + 1'b1;
`else
                        cnt <= line_end ? '0 : cnt + 1'b1;
`endif
                        if (!last_base) begin
                            idx <= idx + 2'd1;
                        end else begin
                            idx <= 2'd0;
                            if (in_xfer) byte_reg <= in_data;
`ifdef NEWLINE_INSERT_EN
                            // Line end always falls on a byte boundary; park any new byte.
                            if (line_end) begin
                                pending <= in_xfer;
                                state   <= NL;
                            end else if (!in_xfer) begin
                                state <= EMPTY;
                            end
`else
                            if (!in_xfer) state <= EMPTY;
`endif
                        end
                    end
                end
`ifdef NEWLINE_INSERT_EN
                NL: begin
                    if (out_ready) begin
                        cnt     <= '0;
                        pending <= 1'b0;
                        state   <= pending ? EMIT : EMPTY;
                    end
                end
`endif
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_gene_line_decompress.sv
// Directed self-checking bench for gene_line_decompress; follows NEWLINE_INSERT_EN if defined.
module tb_gene_line_decompress;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gene_line_decompress #(.LINE_LEN(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hE4;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b want v=0 d=00 l=0",
                     out_valid, out_data, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [4] = '{8'h41, 8'h43, 8'h47, 8'h54};
        do_reset();
        in_data = 8'hE4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== 1'b0) begin
                errors++;
                $display("FAIL single beat %0d got v=%b d=%h l=%b want v=1 d=%h l=0",
                         i, out_valid, out_data, out_last, exp_d[i]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    // Streams nbytes of 8'h00 (nbytes >= 25) and checks the first line plus the overflow.
    task automatic run_line(input int nbytes, input string tag);
        int   acc;
        logic xfer;
        logic exp_last;
        acc = 0;
        in_data = 8'h00;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        xfer = in_valid && in_ready;
        step();
        if (xfer) acc++;
        for (int b = 1; b <= 100; b++) begin
            #1;
`ifdef NEWLINE_INSERT_EN
            exp_last = 1'b0;
`else
            exp_last = (b == 100);
`endif
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h41 || out_last !== exp_last) begin
                errors++;
                $display("FAIL %s beat %0d got v=%b d=%h l=%b want v=1 d=41 l=%b",
                         tag, b, out_valid, out_data, out_last, exp_last);
            end
            xfer = in_valid && in_ready;
            step();
            if (xfer) begin
                acc++;
                if (acc == nbytes) in_valid = 1'b0;
            end
        end
`ifdef NEWLINE_INSERT_EN
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0A || out_last !== 1'b1 || in_ready !== 1'b0)
        begin
            errors++;
            $display("FAIL %s newline got v=%b d=%h l=%b r=%b want v=1 d=0a l=1 r=0",
                     tag, out_valid, out_data, out_last, in_ready);
        end
        step();
`endif
        for (int b = 1; b <= (nbytes - 25) * 4; b++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h41 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL %s next_line beat %0d got v=%b d=%h l=%b want v=1 d=41 l=0",
                         tag, b, out_valid, out_data, out_last);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || acc !== nbytes) begin
            errors++;
            $display("FAIL %s drain got v=%b bytes=%0d want v=0 bytes=%0d",
                     tag, out_valid, acc, nbytes);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_line(26, "b2b");
    endtask

    task automatic test_stall();
        logic [7:0] exp_d [6] = '{8'h54, 8'h47, 8'h47, 8'h47, 8'h43, 8'h41};
        logic       rdy   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        in_data = 8'h1B;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_ready = rdy[i];
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || in_ready !== (i == 5)) begin
                errors++;
                $display("FAIL stall cycle %0d got v=%b d=%h r=%b want v=1 d=%h r=%b",
                         i, out_valid, out_data, in_ready, exp_d[i], (i == 5));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_data = 8'h00;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 50; i++) step();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b l=%b want v=0 r=1 l=0",
                     out_valid, in_ready, out_last);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle got out_valid=%b want 0", out_valid);
        end
        run_line(25, "after_rst");
    endtask

    task automatic test_hold();
        logic [7:0] exp_d [4] = '{8'h41, 8'h43, 8'h47, 8'h54};
        do_reset();
        out_ready = 1'b0;
        in_data = 8'hE4;
        in_valid = 1'b1;
        step();
        in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h41 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d got v=%b d=%h r=%b want v=1 d=41 r=0",
                         i, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_data !== exp_d[i] || in_ready !== (i == 3)) begin
                errors++;
                $display("FAIL hold_release beat %0d got d=%h r=%b want d=%h r=%b",
                         i, out_data, in_ready, exp_d[i], (i == 3));
            end
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h54) begin
                errors++;
                $display("FAIL hold_second beat %0d got v=%b d=%h want v=1 d=54",
                         i, out_valid, out_data);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
